// File: rtl/expipe_pkg.sv
// Shared types and constants for the execution-pipe multiplier issue path.
package expipe_pkg;

    localparam int MULT_NUM_REQ      = 2;
    localparam int MULT_MAX_INFLIGHT = 4;

    localparam int MULT_XLEN       = 32;
    localparam int MULT_IDX_LEN    = 3;
    localparam int MULT_CTL_LEN    = 4;
    localparam int MULT_EXCEPT_LEN = 2;

    typedef struct packed {
        logic [MULT_CTL_LEN-1:0] ctl;
        logic [MULT_XLEN-1:0]    rs1;
        logic [MULT_XLEN-1:0]    rs2;
        logic [MULT_IDX_LEN-1:0] idx;
    } mult_req_t;

    typedef struct packed {
        logic [MULT_XLEN-1:0]       result;
        logic [MULT_IDX_LEN-1:0]    idx;
        logic                       except_raised;
        logic [MULT_EXCEPT_LEN-1:0] except_code;
    } mult_resp_t;

endpackage

// File: rtl/mult_owner_fifo.sv
// In-order record of which requester owns each in-flight multiplier op.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module mult_owner_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [WIDTH-1:0]             data_i,
    output logic [WIDTH-1:0]             head_o,
    output logic [$clog2(DEPTH+1)-1:0]   cnt_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt;

    // Pointer and occupancy bookkeeping; flush discards every entry.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (flush_i) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push_i) tail <= tail + PTR_W'(1);
            if (pop_i)  head <= head + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Owner storage; contents only matter while counted, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_i) mem[tail] <= data_i;
    end

    assign head_o  = mem[head];
    assign cnt_o   = cnt;
    assign full_o  = (cnt == CNT_W'(DEPTH));
    assign empty_o = (cnt == '0);

endmodule

// File: rtl/mult_issue_arbiter.sv
// Round-robin issue arbiter sharing one multiplier between several
// reservation stations, with in-order routing of results back to owners.
// Both the issue and the response paths are purely combinational.
module mult_issue_arbiter
    import expipe_pkg::*;
#(
    parameter int NUM_REQ      = MULT_NUM_REQ,
    parameter int MAX_INFLIGHT = MULT_MAX_INFLIGHT,
    parameter int IDX_LEN      = MULT_IDX_LEN,
    parameter int EU_CTL_LEN   = MULT_CTL_LEN,
    parameter int EXCEPT_LEN   = MULT_EXCEPT_LEN,
    parameter int XLEN         = MULT_XLEN
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic                                 flush_i,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ-1:0][EU_CTL_LEN-1:0]   req_ctl_i,
    input  logic [NUM_REQ-1:0][XLEN-1:0]         req_rs1_i,
    input  logic [NUM_REQ-1:0][XLEN-1:0]         req_rs2_i,
    input  logic [NUM_REQ-1:0][IDX_LEN-1:0]      req_idx_i,
    output logic [NUM_REQ-1:0]                   resp_valid_o,
    input  logic [NUM_REQ-1:0]                   resp_ready_i,
    output logic [XLEN-1:0]                      resp_result_o,
    output logic [IDX_LEN-1:0]                   resp_idx_o,
    output logic                                 resp_except_raised_o,
    output logic [EXCEPT_LEN-1:0]                resp_except_code_o,
    output logic                                 mul_valid_o,
    input  logic                                 mul_ready_i,
    output logic [EU_CTL_LEN-1:0]                mul_ctl_o,
    output logic [XLEN-1:0]                      mul_rs1_o,
    output logic [XLEN-1:0]                      mul_rs2_o,
    output logic [IDX_LEN-1:0]                   mul_idx_o,
    input  logic                                 mul_valid_i,
    output logic                                 mul_ready_o,
    input  logic [XLEN-1:0]                      mul_result_i,
    input  logic [IDX_LEN-1:0]                   mul_idx_i,
    input  logic                                 mul_except_raised_i,
    input  logic [EXCEPT_LEN-1:0]                mul_except_code_i
);

    localparam int SEL_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_INFLIGHT+1);

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] grant;
    logic             any_valid;
    logic [SEL_W-1:0] head_owner;
    logic [CNT_W-1:0] cnt;
    logic             full;
    logic             empty;
    logic             issue_hs;
    logic             retire_hs;

    // (base + off) mod NUM_REQ for operands already below NUM_REQ.
    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                  input logic [SEL_W-1:0] off);
        logic [SEL_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (SEL_W+1)'(NUM_REQ)) sum = sum - (SEL_W+1)'(NUM_REQ);
        return sum[SEL_W-1:0];
    endfunction

    // Pick the first valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        logic [SEL_W-1:0] cand;
        grant     = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = wrap_add(rr_ptr, SEL_W'(i));
            if (!any_valid && req_valid_i[cand]) begin
                grant     = cand;
                any_valid = 1'b1;
            end
        end
    end

    // Issue side: blocked when full or flushing, even if a retire is pending.
    assign mul_valid_o = any_valid && !full && !flush_i;
    assign issue_hs    = mul_valid_o && mul_ready_i;
    assign mul_ctl_o   = req_ctl_i[grant];
    assign mul_rs1_o   = req_rs1_i[grant];
    assign mul_rs2_o   = req_rs2_i[grant];
    assign mul_idx_o   = req_idx_i[grant];

    // One-hot accept back to the granted requester only.
    always_comb begin
        req_ready_o        = '0;
        req_ready_o[grant] = issue_hs;
    end

    // Response side: results belong to the oldest outstanding owner.
    assign mul_ready_o = resp_ready_i[head_owner] && !empty && !flush_i;
    assign retire_hs   = mul_valid_i && mul_ready_o;

    // One-hot result valid toward the head owner only.
    always_comb begin
        resp_valid_o             = '0;
        resp_valid_o[head_owner] = mul_valid_i && !empty && !flush_i;
    end

    assign resp_result_o        = mul_result_i;
    assign resp_idx_o           = mul_idx_i;
    assign resp_except_raised_o = mul_except_raised_i;
    assign resp_except_code_o   = mul_except_code_i;

    // Advance the round-robin pointer past the winner of each issue.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_ptr <= '0;
        end else if (flush_i) begin
            rr_ptr <= '0;
        end else if (issue_hs) begin
            rr_ptr <= wrap_add(grant, SEL_W'(1));
        end
    end

    mult_owner_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (SEL_W)
    ) u_owner_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush_i),
        .push_i  (issue_hs),
        .pop_i   (retire_hs),
        .data_i  (grant),
        .head_o  (head_owner),
        .cnt_o   (cnt),
        .full_o  (full),
        .empty_o (empty)
    );

    // A result with nothing outstanding means the unit broke its contract.
    a_no_orphan_result: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(mul_valid_i && empty));

endmodule

// File: tb/tb_mult_issue_arbiter.sv
// Directed bench for mult_issue_arbiter (NUM_REQ=2, MAX_INFLIGHT=4).
module tb_mult_issue_arbiter;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic             flush_i;
    logic [1:0]       req_valid_i;
    logic [1:0]       req_ready_o;
    logic [1:0][3:0]  req_ctl_i;
    logic [1:0][31:0] req_rs1_i;
    logic [1:0][31:0] req_rs2_i;
    logic [1:0][2:0]  req_idx_i;
    logic [1:0]       resp_valid_o;
    logic [1:0]       resp_ready_i;
    logic [31:0]      resp_result_o;
    logic [2:0]       resp_idx_o;
    logic             resp_except_raised_o;
    logic [1:0]       resp_except_code_o;
    logic             mul_valid_o;
    logic             mul_ready_i;
    logic [3:0]       mul_ctl_o;
    logic [31:0]      mul_rs1_o;
    logic [31:0]      mul_rs2_o;
    logic [2:0]       mul_idx_o;
    logic             mul_valid_i;
    logic             mul_ready_o;
    logic [31:0]      mul_result_i;
    logic [2:0]       mul_idx_i;
    logic             mul_except_raised_i;
    logic [1:0]       mul_except_code_i;

    int n_tests = 0;
    int n_fail  = 0;

    mult_issue_arbiter dut (
        .clk_i                (clk_i),
        .rst_n_i              (rst_n_i),
        .flush_i              (flush_i),
        .req_valid_i          (req_valid_i),
        .req_ready_o          (req_ready_o),
        .req_ctl_i            (req_ctl_i),
        .req_rs1_i            (req_rs1_i),
        .req_rs2_i            (req_rs2_i),
        .req_idx_i            (req_idx_i),
        .resp_valid_o         (resp_valid_o),
        .resp_ready_i         (resp_ready_i),
        .resp_result_o        (resp_result_o),
        .resp_idx_o           (resp_idx_o),
        .resp_except_raised_o (resp_except_raised_o),
        .resp_except_code_o   (resp_except_code_o),
        .mul_valid_o          (mul_valid_o),
        .mul_ready_i          (mul_ready_i),
        .mul_ctl_o            (mul_ctl_o),
        .mul_rs1_o            (mul_rs1_o),
        .mul_rs2_o            (mul_rs2_o),
        .mul_idx_o            (mul_idx_o),
        .mul_valid_i          (mul_valid_i),
        .mul_ready_o          (mul_ready_o),
        .mul_result_i         (mul_result_i),
        .mul_idx_i            (mul_idx_i),
        .mul_except_raised_i  (mul_except_raised_i),
        .mul_except_code_i    (mul_except_code_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_n_i             = 1'b0;
        flush_i             = 1'b0;
        req_valid_i         = 2'b00;
        req_ctl_i[0]        = 4'h1;
        req_ctl_i[1]        = 4'h2;
        req_rs1_i[0]        = 32'd3;
        req_rs2_i[0]        = 32'd5;
        req_rs1_i[1]        = 32'd7;
        req_rs2_i[1]        = 32'd9;
        req_idx_i[0]        = 3'd2;
        req_idx_i[1]        = 3'd5;
        resp_ready_i        = 2'b11;
        mul_ready_i         = 1'b1;
        mul_valid_i         = 1'b0;
        mul_result_i        = '0;
        mul_idx_i           = '0;
        mul_except_raised_i = 1'b0;
        mul_except_code_i   = '0;

        // reset state
        #3;
        chk("rst_req_ready",  req_ready_o, 2'b00);
        chk("rst_resp_valid", resp_valid_o, 2'b00);
        chk("rst_mul_valid",  mul_valid_o, 1'b0);
        chk("rst_mul_ready",  mul_ready_o, 1'b0);
        chk("rst_cnt",        dut.cnt, 0);
        tick();
        tick();
        rst_n_i = 1'b1;

        // single issue from requester 0, then its result
        req_valid_i = 2'b01;
        #1;
        chk("t1_req_ready", req_ready_o, 2'b01);
        chk("t1_mul_valid", mul_valid_o, 1'b1);
        chk("t1_rs1", mul_rs1_o, 3);
        chk("t1_rs2", mul_rs2_o, 5);
        chk("t1_idx", mul_idx_o, 2);
        chk("t1_ctl", mul_ctl_o, 4'h1);
        tick();
        req_valid_i = 2'b00;
        chk("t1_cnt", dut.cnt, 1);
        chk("t1_rr",  dut.rr_ptr, 1);
        mul_valid_i         = 1'b1;
        mul_result_i        = 32'd15;
        mul_idx_i           = 3'd2;
        mul_except_raised_i = 1'b1;
        mul_except_code_i   = 2'd3;
        #1;
        chk("t1_resp_valid",  resp_valid_o, 2'b01);
        chk("t1_resp_result", resp_result_o, 15);
        chk("t1_resp_idx",    resp_idx_o, 2);
        chk("t1_resp_exc",    {resp_except_raised_o, resp_except_code_o}, 3'b111);
        chk("t1_mul_ready",   mul_ready_o, 1'b1);
        tick();
        mul_valid_i         = 1'b0;
        mul_except_raised_i = 1'b0;
        mul_except_code_i   = 2'd0;
        chk("t1_cnt_after", dut.cnt, 0);

        // both valid: rr_ptr is 1, so grants go 1,0,1,0; results retire in order
        begin
            logic [1:0] exp_g [4];
            exp_g = '{2'b10, 2'b01, 2'b10, 2'b01};
            req_valid_i = 2'b11;
            for (int k = 0; k < 4; k++) begin
                mul_valid_i  = (k > 0);
                mul_result_i = 32'(100 + k);
                #1;
                chk($sformatf("t2_grant%0d", k), req_ready_o, exp_g[k]);
                chk($sformatf("t2_rs1_%0d", k), mul_rs1_o, (exp_g[k] == 2'b10) ? 7 : 3);
                if (k > 0) chk($sformatf("t2_resp%0d", k), resp_valid_o, exp_g[k-1]);
                tick();
            end
            req_valid_i = 2'b00;
            chk("t2_cnt", dut.cnt, 1);
            mul_valid_i = 1'b1;
            #1;
            chk("t2_last_resp", resp_valid_o, 2'b01);
            tick();
            mul_valid_i = 1'b0;
            chk("t2_cnt_empty", dut.cnt, 0);
        end

        // no results returned: exactly four issues, then blocked
        req_valid_i = 2'b01;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("t3_ready%0d", k), req_ready_o, (k < 4) ? 2'b01 : 2'b00);
            chk($sformatf("t3_valid%0d", k), mul_valid_o, (k < 4) ? 1'b1 : 1'b0);
            tick();
        end
        chk("t3_cnt_full", dut.cnt, 4);

        // full: retire and pending request together -> no issue this cycle
        mul_valid_i = 1'b1;
        #1;
        chk("t4_mul_valid", mul_valid_o, 1'b0);
        chk("t4_req_ready", req_ready_o, 2'b00);
        chk("t4_mul_ready", mul_ready_o, 1'b1);
        chk("t4_resp",      resp_valid_o, 2'b01);
        tick();
        mul_valid_i = 1'b0;
        chk("t4_cnt3", dut.cnt, 3);
        #1;
        chk("t4_issue_next", req_ready_o, 2'b01);
        tick();
        req_valid_i = 2'b00;
        chk("t4_cnt4", dut.cnt, 4);

        // drain to two, then stall the head owner (requester 0)
        mul_valid_i = 1'b1;
        tick();
        tick();
        chk("t5_cnt2", dut.cnt, 2);
        resp_ready_i = 2'b10;
        mul_result_i = 32'h77;
        #1;
        chk("t5_stall_ready", mul_ready_o, 1'b0);
        chk("t5_stall_valid", resp_valid_o, 2'b01);
        chk("t5_stall_data",  resp_result_o, 32'h77);
        tick();
        chk("t5_cnt_held", dut.cnt, 2);
        resp_ready_i = 2'b01;
        #1;
        chk("t5_release", mul_ready_o, 1'b1);
        tick();
        mul_valid_i  = 1'b0;
        resp_ready_i = 2'b11;
        chk("t5_cnt1", dut.cnt, 1);

        // build cnt=3 with rr_ptr=1, then flush
        req_valid_i = 2'b11;
        #1;
        chk("t6_g1", req_ready_o, 2'b10);
        tick();
        req_valid_i = 2'b01;
        tick();
        chk("t6_cnt3", dut.cnt, 3);
        chk("t6_rr1",  dut.rr_ptr, 1);
        flush_i     = 1'b1;
        req_valid_i = 2'b11;
        mul_valid_i = 1'b1;
        #1;
        chk("t6_fl_mul_valid", mul_valid_o, 1'b0);
        chk("t6_fl_req_ready", req_ready_o, 2'b00);
        chk("t6_fl_mul_ready", mul_ready_o, 1'b0);
        chk("t6_fl_resp",      resp_valid_o, 2'b00);
        tick();
        flush_i     = 1'b0;
        mul_valid_i = 1'b0;
        chk("t6_cnt0", dut.cnt, 0);
        chk("t6_rr0",  dut.rr_ptr, 0);
        #1;
        chk("t6_regrant", req_ready_o, 2'b01);
        tick();
        req_valid_i = 2'b00;
        chk("t6_cnt_new", dut.cnt, 1);
        mul_valid_i = 1'b1;
        #1;
        chk("t6_resp_owner", resp_valid_o, 2'b01);
        tick();
        mul_valid_i = 1'b0;
        chk("t6_cnt_end", dut.cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
